// File: rtl/alu_disp_pkg.sv
// Shared FSM state type and active-high seven-segment glyphs (bit 0 = a, bit 6 = g).
package alu_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3, one bit per cycle).
// done_o marks the last iteration; bcd_o then carries the final result combinationally.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [19:0] bcd_o
);

    logic [15:0] sh_q;
    logic [19:0] acc_q, acc_adj, acc_d;
    logic [3:0]  cnt_q;
    logic        busy_q;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_d = {acc_adj[18:0], sh_q[15]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            sh_q   <= bin_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            sh_q  <= {sh_q[14:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15)
                busy_q <= 1'b0;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 4'd15);
    assign bcd_o  = acc_d;

endmodule

// File: rtl/result_bcd_display.sv
// Captures a signed 16-bit result, converts its magnitude to BCD and scans it onto a
// 6-digit multiplexed seven-segment display (sign/error digit on index 5).
module result_bcd_display
    import alu_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sum,
    input  logic        in_overflow,
    output logic        done,
    output logic [19:0] bcd,
    output logic        neg,
    output logic        err,
    output logic [6:0]  seg,
    output logic [5:0]  digit_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_e          state_q, state_d;
    logic            in_ready_q, done_q, neg_q, err_q, sign_q, ovf_q;
    logic [19:0]     bcd_q;
    logic [PW-1:0]   pre_q;
    logic [2:0]      idx_q;
    logic [6:0]      seg_q, glyph;
    logic [5:0]      sel_q;

    logic [15:0]     s, mag;
    logic            accept, cv_busy, cv_done, unused_hi_bits;
    logic [19:0]     cv_bcd;
    logic [4:0][3:0] digs;
    logic [4:0]      zero_above;

    assign s              = in_sum[15:0];
    assign unused_hi_bits = ^in_sum[31:16];
    // 16 bits suffice: -32768 negates to 0x8000, which is 32768 read as unsigned.
    assign mag            = s[15] ? (~s + 16'd1) : s;
    assign accept         = in_valid && in_ready_q && (state_q == IDLE);

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset   (reset),
        .start_i (accept),
        .bin_i   (mag),
        .busy_o  (cv_busy),
        .done_o  (cv_done),
        .bcd_o   (cv_bcd)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CONV;
            CONV:    if (cv_done && cv_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == IDLE);
            done_q     <= (state_d == DONE);
            if (accept) begin
                sign_q <= s[15];
                ovf_q  <= in_overflow;
            end
            // Display registers load on entry to DONE so done and the new value coincide.
            if (state_q == CONV && state_d == DONE) begin
                bcd_q <= cv_bcd;
                neg_q <= sign_q;
                err_q <= ovf_q;
            end
        end
    end

    always_comb begin
        digs          = bcd_q;
        zero_above[4] = (digs[4] == 4'd0);
        for (int k = 3; k >= 0; k--)
            zero_above[k] = zero_above[k+1] && (digs[k] == 4'd0);
        glyph = SEG_BLANK;
        if (idx_q == 3'd5) begin
            if (err_q)      glyph = SEG_E;
            else if (neg_q) glyph = SEG_MINUS;
        end else if (!(BLANK_LZ && idx_q != 3'd0 && zero_above[idx_q])) begin
            glyph = seg_of(digs[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            if (pre_q == PW'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
            seg_q <= glyph;
            sel_q <= 6'b000001 << idx_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign neg       = neg_q;
    assign err       = err_q;
    assign seg       = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display with a fast scan (SCAN_DIV=2).
module tb_result_bcd_display;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_overflow;
    logic [31:0] in_sum;
    logic        in_ready, done, neg, err;
    logic [19:0] bcd;
    logic [6:0]  seg;
    logic [5:0]  digit_sel;

    int errors = 0;
    int checks = 0;

    result_bcd_display #(.SCAN_DIV(2), .BLANK_LZ(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_overflow (in_overflow),
        .done        (done),
        .bcd         (bcd),
        .neg         (neg),
        .err         (err),
        .seg         (seg),
        .digit_sel   (digit_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake one value, then measure cycles until done (bounded).
    task automatic send(input logic [31:0] v, input logic o, input string tag);
        int k;
        bit seen;
        @(negedge clk);
        check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_sum = v; in_overflow = o;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1; seen = 1'b0;
        while (!seen && k < 40) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, " latency"}, k, 32'd17);
    endtask

    // Twelve samples cover every scan index twice; seg is checked against the index shown.
    task automatic scan_check(input string tag, input logic [5:0][6:0] exp);
        logic [5:0] seen_mask;
        seen_mask = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check({tag, " onehot"}, {31'd0, $onehot(digit_sel)}, 32'd1);
            for (int i = 0; i < 6; i++) begin
                if (digit_sel[i]) begin
                    seen_mask[i] = 1'b1;
                    check($sformatf("%s seg%0d", tag, i), {25'd0, seg}, {25'd0, exp[i]});
                end
            end
        end
        check({tag, " all digits"}, {26'd0, seen_mask}, 32'h3F);
    endtask

    initial begin
        int ndone, first_k, second_k;
        logic [19:0] b1, b2;
        logic [5:0] sel_exp [13];
        bit done_seen;

        reset = 1'b1; in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'd0, in_ready}, 32'd0);
        check("rst done",  {31'd0, done}, 32'd0);
        check("rst bcd",   {12'd0, bcd}, 32'd0);
        check("rst seg",   {25'd0, seg}, 32'd0);
        check("rst sel",   {26'd0, digit_sel}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post ready", {31'd0, in_ready}, 32'd1);
        check("post sel",   {26'd0, digit_sel}, 32'h01);
        check("post seg",   {25'd0, seg}, 32'h3F);
        scan_check("zero", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'b0111111});

        send(32'h00000005, 1'b0, "pos5");
        check("pos5 bcd", {12'd0, bcd}, 32'h00005);
        check("pos5 neg", {31'd0, neg}, 32'd0);
        @(negedge clk);
        check("pos5 done pulse", {31'd0, done}, 32'd0);
        scan_check("pos5", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'b1101101});

        send(32'hFFFF8000, 1'b0, "min");
        check("min bcd", {12'd0, bcd}, 32'h32768);
        check("min neg", {31'd0, neg}, 32'd1);
        check("min err", {31'd0, err}, 32'd0);
        scan_check("min", {7'b1000000, 7'b1001111, 7'b1011011, 7'b0000111, 7'b1111101, 7'b1111111});

        send(32'hFFFFFFFB, 1'b0, "neg5");
        check("neg5 bcd", {12'd0, bcd}, 32'h00005);
        check("neg5 neg", {31'd0, neg}, 32'd1);
        scan_check("neg5", {7'b1000000, 7'h00, 7'h00, 7'h00, 7'h00, 7'b1101101});

        send(32'h00000007, 1'b1, "ovf7");
        check("ovf7 bcd", {12'd0, bcd}, 32'h00007);
        check("ovf7 err", {31'd0, err}, 32'd1);
        check("ovf7 neg", {31'd0, neg}, 32'd0);
        scan_check("ovf7", {7'b1111001, 7'h00, 7'h00, 7'h00, 7'h00, 7'b0000111});

        // Back-to-back: valid held high through CONV with a second value queued upstream.
        @(negedge clk);
        in_valid = 1'b1; in_sum = 32'd123; in_overflow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_sum = 32'd456;
        ndone = 0; first_k = 0; second_k = 0; b1 = '0; b2 = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin first_k = k; b1 = bcd; end
                else begin second_k = k; b2 = bcd; end
            end
            if (k == 5)  check("b2b busy ready", {31'd0, in_ready}, 32'd0);
            if (k == 16) check("b2b hold old", {12'd0, bcd}, 32'h00007);
            if (k == 18) check("b2b idle ready", {31'd0, in_ready}, 32'd1);
            if (k == 19) in_valid = 1'b0;
            if (k == 30) check("b2b hold first", {12'd0, bcd}, 32'h00123);
        end
        check("b2b ndone", ndone, 32'd2);
        check("b2b first k", first_k, 32'd17);
        check("b2b second k", second_k, 32'd35);
        check("b2b first bcd", {12'd0, b1}, 32'h00123);
        check("b2b second bcd", {12'd0, b2}, 32'h00456);

        // Reset in the middle of a conversion.
        sel_exp = '{6'h01, 6'h01, 6'h02, 6'h02, 6'h04, 6'h04, 6'h08, 6'h08,
                    6'h10, 6'h10, 6'h20, 6'h20, 6'h01};
        @(negedge clk);
        in_valid = 1'b1; in_sum = 32'hFFFF8000; in_overflow = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst old bcd", {12'd0, bcd}, 32'h00456);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst sel in reset", {26'd0, digit_sel}, 32'd0);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            check($sformatf("midrst sel%0d", n), {26'd0, digit_sel}, {26'd0, sel_exp[n]});
            if (done) done_seen = 1'b1;
        end
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("midrst no done", {31'd0, done_seen}, 32'd0);
        check("midrst bcd", {12'd0, bcd}, 32'd0);
        check("midrst neg", {31'd0, neg}, 32'd0);
        check("midrst err", {31'd0, err}, 32'd0);
        check("midrst ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
